// File: rtl/clock_set_ctrl.sv
// Time-setting controller: debounced mode/inc/dec keys drive a RUN/SET_HOUR/SET_MIN/COMMIT
// FSM that freezes the seconds tick while editing and issues a single load of the edited time.
module clock_set_ctrl #(
   parameter int DEBOUNCE_CYC      = 1000000,
   parameter int REPEAT_DELAY_CYC  = 25000000,
   parameter int REPEAT_PERIOD_CYC = 10000000,
   parameter int BLINK_CYC         = 12500000,
   parameter int TIMEOUT_CYC       = 500000000
) (
   input  logic       CLOCK_50,
   input  logic       reset_n,
   input  logic       key_mode_n,
   input  logic       key_inc_n,
   input  logic       key_dec_n,
   input  logic [4:0] cur_hour,
   input  logic [5:0] cur_min,
   output logic       run_en,
   output logic       load,
   output logic [4:0] load_hour,
   output logic [5:0] load_min,
   output logic [5:0] load_sec,
   output logic [1:0] set_mode,
   output logic       blink
);
   localparam int DW   = $clog2(DEBOUNCE_CYC + 1);
   localparam int RMAX = (REPEAT_DELAY_CYC > REPEAT_PERIOD_CYC) ? REPEAT_DELAY_CYC : REPEAT_PERIOD_CYC;
   localparam int RW   = $clog2(RMAX + 1);
   localparam int BW   = $clog2(BLINK_CYC + 1);
   localparam int TW   = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {ST_RUN, ST_SET_HOUR, ST_SET_MIN, ST_COMMIT} state_t;

   logic [2:0] key_n;
   logic [2:0] key_pulse;   // [0] mode, [1] inc, [2] dec
   assign key_n = {key_dec_n, key_inc_n, key_mode_n};

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_key
         localparam bit HAS_REPEAT = (gi != 0);
         logic          sync1_reg, sync2_reg, level_reg, repeating_reg, pulse_reg;
         logic [DW-1:0] deb_cnt_reg;
         logic [RW-1:0] rep_cnt_reg;
         logic          pressed_sync, flip, rep_hit;

         assign pressed_sync = ~sync2_reg;
         assign flip    = (pressed_sync != level_reg) && (deb_cnt_reg == DW'(DEBOUNCE_CYC - 1));
         assign rep_hit = rep_cnt_reg == (repeating_reg ? RW'(REPEAT_PERIOD_CYC - 1)
                                                        : RW'(REPEAT_DELAY_CYC - 1));

         always_ff @(posedge CLOCK_50) begin
            if (!reset_n) begin
               sync1_reg     <= 1'b1;
               sync2_reg     <= 1'b1;
               level_reg     <= 1'b0;
               deb_cnt_reg   <= '0;
               rep_cnt_reg   <= '0;
               repeating_reg <= 1'b0;
               pulse_reg     <= 1'b0;
            end else begin
               sync1_reg <= key_n[gi];
               sync2_reg <= sync1_reg;
               pulse_reg <= 1'b0;
               if (pressed_sync == level_reg || flip)
                  deb_cnt_reg <= '0;
               else
                  deb_cnt_reg <= deb_cnt_reg + 1'b1;
               if (flip)
                  level_reg <= pressed_sync;
               // No repeat pulse on the edge where the debounced release lands
               if (flip && pressed_sync) begin
                  pulse_reg     <= 1'b1;
                  rep_cnt_reg   <= '0;
                  repeating_reg <= 1'b0;
               end else if (HAS_REPEAT && level_reg && !flip) begin
                  if (rep_hit) begin
                     pulse_reg     <= 1'b1;
                     rep_cnt_reg   <= '0;
                     repeating_reg <= 1'b1;
                  end else begin
                     rep_cnt_reg <= rep_cnt_reg + 1'b1;
                  end
               end else begin
                  rep_cnt_reg   <= '0;
                  repeating_reg <= 1'b0;
               end
            end
         end

         assign key_pulse[gi] = pulse_reg;
      end
   endgenerate

   logic mode_p, inc_p, dec_p, any_p;
   assign mode_p = key_pulse[0];
   assign inc_p  = key_pulse[1] & ~key_pulse[2];
   assign dec_p  = key_pulse[2] & ~key_pulse[1];
   assign any_p  = |key_pulse;

   state_t        state_reg;
   logic [4:0]    edit_hour_reg;
   logic [5:0]    edit_min_reg;
   logic          run_en_reg, load_reg, blink_reg;
   logic [1:0]    set_mode_reg;
   logic [BW-1:0] blink_cnt_reg;
   logic [TW-1:0] idle_cnt_reg;

   always_ff @(posedge CLOCK_50) begin
      if (!reset_n) begin
         state_reg     <= ST_RUN;
         edit_hour_reg <= '0;
         edit_min_reg  <= '0;
         run_en_reg    <= 1'b1;
         load_reg      <= 1'b0;
         set_mode_reg  <= 2'd0;
         blink_reg     <= 1'b0;
         blink_cnt_reg <= '0;
         idle_cnt_reg  <= '0;
      end else begin
         load_reg <= 1'b0;
         case (state_reg)
            ST_RUN: begin
               run_en_reg   <= 1'b1;
               set_mode_reg <= 2'd0;
               blink_reg    <= 1'b0;
               if (mode_p) begin
                  edit_hour_reg <= cur_hour;
                  edit_min_reg  <= cur_min;
                  state_reg     <= ST_SET_HOUR;
                  run_en_reg    <= 1'b0;
                  set_mode_reg  <= 2'd1;
                  blink_reg     <= 1'b1;
                  blink_cnt_reg <= '0;
                  idle_cnt_reg  <= '0;
               end
            end
            ST_SET_HOUR, ST_SET_MIN: begin
               if (blink_cnt_reg == BW'(BLINK_CYC - 1)) begin
                  blink_reg     <= ~blink_reg;
                  blink_cnt_reg <= '0;
               end else begin
                  blink_cnt_reg <= blink_cnt_reg + 1'b1;
               end
               idle_cnt_reg <= any_p ? '0 : idle_cnt_reg + 1'b1;
               // Mode beats a simultaneous edit; a cancelled inc+dec still counts as activity
               if (mode_p) begin
                  blink_cnt_reg <= '0;
                  if (state_reg == ST_SET_HOUR) begin
                     state_reg    <= ST_SET_MIN;
                     set_mode_reg <= 2'd2;
                     blink_reg    <= 1'b1;
                  end else begin
                     state_reg    <= ST_COMMIT;
                     set_mode_reg <= 2'd0;
                     load_reg     <= 1'b1;
                     blink_reg    <= 1'b0;
                  end
               end else if (inc_p || dec_p) begin
                  blink_reg     <= 1'b1;
                  blink_cnt_reg <= '0;
                  if (state_reg == ST_SET_HOUR) begin
                     if (inc_p)
                        edit_hour_reg <= (edit_hour_reg == 5'd23) ? 5'd0 : edit_hour_reg + 5'd1;
                     else
                        edit_hour_reg <= (edit_hour_reg == 5'd0) ? 5'd23 : edit_hour_reg - 5'd1;
                  end else begin
                     if (inc_p)
                        edit_min_reg <= (edit_min_reg == 6'd59) ? 6'd0 : edit_min_reg + 6'd1;
                     else
                        edit_min_reg <= (edit_min_reg == 6'd0) ? 6'd59 : edit_min_reg - 6'd1;
                  end
               end else if (!any_p && idle_cnt_reg == TW'(TIMEOUT_CYC - 1)) begin
                  state_reg    <= ST_RUN;
                  run_en_reg   <= 1'b1;
                  set_mode_reg <= 2'd0;
                  blink_reg    <= 1'b0;
               end
            end
            default: begin
               state_reg  <= ST_RUN;
               run_en_reg <= 1'b1;
            end
         endcase
      end
   end

   assign run_en    = run_en_reg;
   assign load      = load_reg;
   assign load_hour = edit_hour_reg;
   assign load_min  = edit_min_reg;
   assign load_sec  = 6'd0;
   assign set_mode  = set_mode_reg;
   assign blink     = blink_reg;
endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: randomized key sequences checked against an
// arithmetic model of the edit fields, key latency, auto-repeat schedule and timeout.
module tb_clock_set_ctrl;
   localparam int D   = 4;
   localparam int RD  = 20;
   localparam int RP  = 5;
   localparam int B   = 8;
   localparam int T   = 200;
   localparam int LAT = D + 3;   // raw press to visible FSM effect, in sampled ticks

   logic       clk = 1'b0;
   logic       reset_n, key_mode_n, key_inc_n, key_dec_n;
   logic [4:0] cur_hour;
   logic [5:0] cur_min;
   logic       run_en, load, blink;
   logic [4:0] load_hour;
   logic [5:0] load_min, load_sec;
   logic [1:0] set_mode;

   int n_cmp = 0;
   int n_bad = 0;
   int load_seen = 0;
   int run_bad = 0;
   int cap_h, cap_m, cap_s, cap_run, run_after;
   bit prev_load = 1'b0;
   int obs_h, obs_m, obs_mode;

   clock_set_ctrl #(
      .DEBOUNCE_CYC(D), .REPEAT_DELAY_CYC(RD), .REPEAT_PERIOD_CYC(RP),
      .BLINK_CYC(B), .TIMEOUT_CYC(T)
   ) dut (
      .CLOCK_50(clk), .reset_n(reset_n),
      .key_mode_n(key_mode_n), .key_inc_n(key_inc_n), .key_dec_n(key_dec_n),
      .cur_hour(cur_hour), .cur_min(cur_min),
      .run_en(run_en), .load(load), .load_hour(load_hour), .load_min(load_min),
      .load_sec(load_sec), .set_mode(set_mode), .blink(blink)
   );

   always #5 clk = ~clk;

   // Observer: records load strobes and any cycle where an edit state lets time run
   always @(posedge clk) begin
      #1;
      if (prev_load) run_after = int'(run_en);
      if (load === 1'b1) begin
         load_seen++;
         cap_h   = int'(load_hour);
         cap_m   = int'(load_min);
         cap_s   = int'(load_sec);
         cap_run = int'(run_en);
      end
      prev_load = (load === 1'b1);
      if (set_mode != 2'd0 && run_en === 1'b1) run_bad++;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input bit m, input bit i, input bit d, input int hold, input int gap);
      key_mode_n = ~m;
      key_inc_n  = ~i;
      key_dec_n  = ~d;
      for (int t = 1; t <= hold + gap; t++) begin
         @(negedge clk);
         if (t == LAT) begin
            obs_h    = int'(load_hour);
            obs_m    = int'(load_min);
            obs_mode = int'(set_mode);
         end
         if (t == hold) begin
            key_mode_n = 1'b1;
            key_inc_n  = 1'b1;
            key_dec_n  = 1'b1;
         end
      end
      $display("press mode=%0d inc=%0d dec=%0d hold=%0d -> set_mode=%0d hour=%0d min=%0d",
               m, i, d, hold, obs_mode, obs_h, obs_m);
   endtask

   // Auto-repeat schedule: pulses at offsets 0, RD, RD+RP, ... while held r cycles
   function automatic int rep_pulses(input int r, input int upto);
      int n = 0;
      for (int o = 0; o < r && o <= upto; o = (o == 0) ? RD : o + RP) n++;
      return n;
   endfunction

   task automatic test_reset;
      int base;
      reset_n = 1'b0; key_mode_n = 1'b1; key_inc_n = 1'b1; key_dec_n = 1'b1;
      cur_hour = 5'd7; cur_min = 6'd33;
      tick(3);
      n_cmp++; if (run_en !== 1'b1) begin n_bad++; $display("FAIL reset_run_en: got %0b want 1", run_en); end
      n_cmp++; if (load !== 1'b0) begin n_bad++; $display("FAIL reset_load: got %0b want 0", load); end
      n_cmp++; if (set_mode !== 2'd0) begin n_bad++; $display("FAIL reset_set_mode: got %0d want 0", set_mode); end
      n_cmp++; if (blink !== 1'b0) begin n_bad++; $display("FAIL reset_blink: got %0b want 0", blink); end
      n_cmp++; if ({load_hour, load_min, load_sec} !== 17'd0) begin n_bad++;
         $display("FAIL reset_load_vals: got %0d:%0d:%0d want 0:0:0", load_hour, load_min, load_sec); end
      base = load_seen;
      reset_n = 1'b1;
      tick(50);
      n_cmp++; if (load_seen != base) begin n_bad++; $display("FAIL idle_loads: got %0d want 0", load_seen - base); end
      n_cmp++; if (set_mode !== 2'd0 || run_en !== 1'b1) begin n_bad++;
         $display("FAIL idle_mode: got set_mode=%0d run_en=%0b want 0/1", set_mode, run_en); end
      n_cmp++; if (load_hour !== 5'd0) begin n_bad++; $display("FAIL idle_capture: got %0d want 0", load_hour); end
   endtask

   task automatic test_edit_commit;
      for (int it = 0; it < 4; it++) begin
         int ch, cm, eh, em, ni, nd, base, rb, dir;
         ch = (it == 0) ? 13 : $urandom_range(0, 23);
         cm = (it == 0) ? 45 : $urandom_range(0, 59);
         ni = (it == 0) ? 3  : $urandom_range(0, 30);
         nd = (it == 0) ? 50 : $urandom_range(0, 30);
         cur_hour = 5'(ch); cur_min = 6'(cm);
         base = load_seen; rb = run_bad;
         press(1, 0, 0, $urandom_range(6, 15), $urandom_range(8, 14));
         cur_hour = 5'($urandom_range(0, 23)); cur_min = 6'($urandom_range(0, 59));
         n_cmp++; if (obs_mode != 1 || obs_h != ch || obs_m != cm) begin n_bad++;
            $display("FAIL capture: got mode=%0d %0d:%0d want 1 %0d:%0d", obs_mode, obs_h, obs_m, ch, cm); end
         eh = ch; em = cm;
         for (int k = 0; k < ni; k++) begin
            dir = (it == 0) ? 0 : $urandom_range(0, 1);
            eh = (dir == 0) ? (eh + 1) % 24 : (eh + 23) % 24;
            press(0, dir == 0, dir == 1, $urandom_range(6, 15), $urandom_range(8, 14));
            n_cmp++; if (obs_h != eh) begin n_bad++; $display("FAIL edit_hour: got %0d want %0d", obs_h, eh); end
         end
         press(1, 0, 0, $urandom_range(6, 15), $urandom_range(8, 14));
         n_cmp++; if (obs_mode != 2 || obs_h != eh) begin n_bad++;
            $display("FAIL to_set_min: got mode=%0d hour=%0d want 2 %0d", obs_mode, obs_h, eh); end
         for (int k = 0; k < nd; k++) begin
            dir = (it == 0) ? 1 : $urandom_range(0, 1);
            em = (dir == 0) ? (em + 1) % 60 : (em + 59) % 60;
            press(0, dir == 0, dir == 1, $urandom_range(6, 15), $urandom_range(8, 14));
            n_cmp++; if (obs_m != em) begin n_bad++; $display("FAIL edit_min: got %0d want %0d", obs_m, em); end
         end
         press(1, 0, 0, $urandom_range(6, 15), $urandom_range(8, 14));
         n_cmp++; if (load_seen - base != 1) begin n_bad++; $display("FAIL load_count: got %0d want 1", load_seen - base); end
         n_cmp++; if (cap_h != eh || cap_m != em || cap_s != 0) begin n_bad++;
            $display("FAIL load_value: got %0d:%0d:%0d want %0d:%0d:0", cap_h, cap_m, cap_s, eh, em); end
         n_cmp++; if (cap_run != 0 || run_after != 1) begin n_bad++;
            $display("FAIL load_run_en: got %0d then %0d want 0 then 1", cap_run, run_after); end
         n_cmp++; if (run_bad != rb) begin n_bad++; $display("FAIL edit_run_en: got %0d running cycles want 0", run_bad - rb); end
      end
   endtask

   task automatic test_wrap;
      cur_hour = 5'd23; cur_min = 6'd59;
      press(1, 0, 0, 8, 10);
      press(0, 1, 0, 8, 10);
      n_cmp++; if (obs_h != 0) begin n_bad++; $display("FAIL wrap_hour_up: got %0d want 0", obs_h); end
      press(0, 0, 1, 8, 10);
      n_cmp++; if (obs_h != 23) begin n_bad++; $display("FAIL wrap_hour_down: got %0d want 23", obs_h); end
      press(1, 0, 0, 8, 10);
      press(0, 1, 0, 8, 10);
      n_cmp++; if (obs_m != 0) begin n_bad++; $display("FAIL wrap_min_up: got %0d want 0", obs_m); end
      press(0, 0, 1, 8, 10);
      n_cmp++; if (obs_m != 59) begin n_bad++; $display("FAIL wrap_min_down: got %0d want 59", obs_m); end
      press(1, 0, 0, 8, 10);
      n_cmp++; if (cap_h != 23 || cap_m != 59) begin n_bad++;
         $display("FAIL wrap_load: got %0d:%0d want 23:59", cap_h, cap_m); end
   endtask

   task automatic test_glitch;
      int ch, eh, base;
      ch = $urandom_range(0, 23);
      cur_hour = 5'(ch); cur_min = 6'($urandom_range(0, 59));
      base = load_seen;
      press(1, 0, 0, 8, 10);
      eh = ch;
      for (int i = 0; i < 30; i++) begin
         key_inc_n = ((i / 2) % 2 == 0) ? 1'b1 : 1'b0;
         tick(1);
      end
      n_cmp++; if (load_hour !== 5'(eh)) begin n_bad++; $display("FAIL glitch_quiet: got %0d want %0d", load_hour, eh); end
      key_inc_n = 1'b0;
      for (int t = 1; t <= LAT + 20; t++) begin
         @(negedge clk);
         if (t == LAT - 1) begin
            n_cmp++; if (load_hour !== 5'(eh)) begin n_bad++; $display("FAIL glitch_early: got %0d want %0d", load_hour, eh); end
         end
         if (t == LAT) begin
            n_cmp++; if (load_hour !== 5'((eh + 1) % 24)) begin n_bad++;
               $display("FAIL glitch_pulse: got %0d want %0d", load_hour, (eh + 1) % 24); end
         end
         if (t == 12) key_inc_n = 1'b1;
      end
      eh = (eh + 1) % 24;
      n_cmp++; if (load_hour !== 5'(eh)) begin n_bad++; $display("FAIL glitch_single: got %0d want %0d", load_hour, eh); end
      press(1, 0, 0, 8, 10);
      press(1, 0, 0, 8, 10);
      n_cmp++; if (load_seen - base != 1 || cap_h != eh) begin n_bad++;
         $display("FAIL glitch_load: got %0d loads hour=%0d want 1 hour=%0d", load_seen - base, cap_h, eh); end
   endtask

   task automatic test_repeat;
      for (int it = 0; it < 4; it++) begin
         int cm, r, ex, em, base;
         cm = (it == 0) ? 10 : $urandom_range(0, 59);
         r  = (it == 0) ? 60 : $urandom_range(8, 70);
         cur_min = 6'(cm); cur_hour = 5'($urandom_range(0, 23));
         base = load_seen;
         press(1, 0, 0, 8, 10);
         press(1, 0, 0, 8, 10);
         key_inc_n = 1'b0;
         for (int t = 1; t <= r + LAT + 10; t++) begin
            @(negedge clk);
            if (t == r) key_inc_n = 1'b1;
            ex = (cm + rep_pulses(r, t - LAT)) % 60;
            n_cmp++; if (load_min !== 6'(ex)) begin n_bad++;
               $display("FAIL repeat_t%0d: got %0d want %0d (hold %0d)", t, load_min, ex, r); end
         end
         em = (cm + rep_pulses(r, r)) % 60;
         $display("repeat hold=%0d start=%0d -> min=%0d", r, cm, load_min);
         press(1, 0, 0, 8, 10);
         n_cmp++; if (load_seen - base != 1 || cap_m != em) begin n_bad++;
            $display("FAIL repeat_load: got %0d loads min=%0d want 1 min=%0d", load_seen - base, cap_m, em); end
      end
   endtask

   task automatic test_timeout;
      int base;
      cur_hour = 5'($urandom_range(0, 23)); cur_min = 6'($urandom_range(0, 59));
      base = load_seen;
      key_mode_n = 1'b0;
      for (int t = 1; t <= LAT + T + 5; t++) begin
         @(negedge clk);
         if (t == 8) key_mode_n = 1'b1;
         if (t == LAT) begin
            n_cmp++; if (set_mode !== 2'd1 || run_en !== 1'b0) begin n_bad++;
               $display("FAIL to_enter: got set_mode=%0d run_en=%0b want 1/0", set_mode, run_en); end
            n_cmp++; if (blink !== 1'b1) begin n_bad++; $display("FAIL to_blink_entry: got %0b want 1", blink); end
         end
         if (t == LAT + B - 1) begin
            n_cmp++; if (blink !== 1'b1) begin n_bad++; $display("FAIL to_blink_hold: got %0b want 1", blink); end
         end
         if (t == LAT + B) begin
            n_cmp++; if (blink !== 1'b0) begin n_bad++; $display("FAIL to_blink_off: got %0b want 0", blink); end
         end
         if (t == LAT + 2 * B) begin
            n_cmp++; if (blink !== 1'b1) begin n_bad++; $display("FAIL to_blink_on: got %0b want 1", blink); end
         end
         if (t == LAT + T - 1) begin
            n_cmp++; if (set_mode !== 2'd1) begin n_bad++; $display("FAIL to_early: got %0d want 1", set_mode); end
         end
         if (t == LAT + T) begin
            n_cmp++; if (set_mode !== 2'd0 || run_en !== 1'b1 || blink !== 1'b0) begin n_bad++;
               $display("FAIL to_expire: got set_mode=%0d run_en=%0b blink=%0b want 0/1/0", set_mode, run_en, blink); end
         end
      end
      n_cmp++; if (load_seen != base) begin n_bad++; $display("FAIL to_no_load: got %0d want 0", load_seen - base); end
      $display("timeout -> set_mode=%0d run_en=%0b", set_mode, run_en);
   endtask

   task automatic test_reset_mid;
      int cm, base;
      cm = $urandom_range(0, 59);
      cur_hour = 5'($urandom_range(1, 23)); cur_min = 6'(cm);
      base = load_seen;
      press(1, 0, 0, 8, 10);
      press(1, 0, 0, 8, 10);
      press(0, 1, 0, 8, 10);
      n_cmp++; if (obs_m != (cm + 1) % 60) begin n_bad++; $display("FAIL mid_edit: got %0d want %0d", obs_m, (cm + 1) % 60); end
      reset_n = 1'b0;
      tick(2);
      reset_n = 1'b1;
      tick(1);
      n_cmp++; if (set_mode !== 2'd0 || run_en !== 1'b1 || blink !== 1'b0) begin n_bad++;
         $display("FAIL mid_reset_state: got set_mode=%0d run_en=%0b blink=%0b want 0/1/0", set_mode, run_en, blink); end
      n_cmp++; if (load_hour !== 5'd0 || load_min !== 6'd0) begin n_bad++;
         $display("FAIL mid_reset_edit: got %0d:%0d want 0:0", load_hour, load_min); end
      tick(20);
      n_cmp++; if (load_seen != base || set_mode !== 2'd0) begin n_bad++;
         $display("FAIL mid_reset_after: got %0d loads set_mode=%0d want 0/0", load_seen - base, set_mode); end
      $display("mid-edit reset -> set_mode=%0d loads=%0d", set_mode, load_seen - base);
   endtask

   task automatic test_back_to_back;
      int ch, cm, base;
      ch = $urandom_range(0, 23); cm = $urandom_range(0, 59);
      cur_hour = 5'(ch); cur_min = 6'(cm);
      base = load_seen;
      press(1, 0, 0, 8, 10);
      press(1, 1, 0, 8, 10);
      n_cmp++; if (obs_mode != 2 || obs_h != ch) begin n_bad++;
         $display("FAIL mode_beats_inc: got mode=%0d hour=%0d want 2 %0d", obs_mode, obs_h, ch); end
      press(0, 1, 1, 8, 10);
      n_cmp++; if (obs_m != cm || obs_mode != 2) begin n_bad++;
         $display("FAIL inc_dec_cancel: got mode=%0d min=%0d want 2 %0d", obs_mode, obs_m, cm); end
      tick(120);
      key_inc_n = 1'b0; key_dec_n = 1'b0;
      for (int t = 1; t <= LAT + T + 2; t++) begin
         @(negedge clk);
         if (t == 8) begin key_inc_n = 1'b1; key_dec_n = 1'b1; end
         if (t == LAT + T - 1) begin
            n_cmp++; if (set_mode !== 2'd2) begin n_bad++; $display("FAIL cancel_restarts_idle: got %0d want 2", set_mode); end
         end
         if (t == LAT + T) begin
            n_cmp++; if (set_mode !== 2'd0) begin n_bad++; $display("FAIL cancel_timeout: got %0d want 0", set_mode); end
         end
      end
      n_cmp++; if (load_min !== 6'(cm) || load_seen != base) begin n_bad++;
         $display("FAIL b2b_final: got min=%0d loads=%0d want %0d/0", load_min, load_seen - base, cm); end
      $display("back-to-back -> set_mode=%0d min=%0d", set_mode, load_min);
   endtask

   initial begin
      test_reset;
      test_edit_commit;
      test_wrap;
      test_glitch;
      test_repeat;
      test_timeout;
      test_reset_mid;
      test_back_to_back;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
